// File: rtl/block_fetch_sequencer_if.sv
// Request / BRAM / window bus of block_fetch_sequencer.
// master = sequencer side, slave = requester, BRAM and consumer side.
interface block_fetch_sequencer_if #(
  parameter int unsigned BLOCK_SIZE = 6,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_ROWS   = 320,
  parameter int unsigned ROW_WORDS  = 40
);
  localparam int unsigned ROW_W  = $clog2(IMG_ROWS);
  localparam int unsigned COL_W  = $clog2(ROW_WORDS);
  localparam int unsigned ADDR_W = $clog2(IMG_ROWS * ROW_WORDS);
  localparam int unsigned WORD_W = BLOCK_SIZE * PIX_W;
  localparam int unsigned WIN_W  = BLOCK_SIZE * WORD_W;

  logic              req_valid;
  logic              req_ready;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic              req_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [WORD_W-1:0] mem_dout;
  logic              win_valid;
  logic              win_ready;
  logic [WIN_W-1:0]  win_data;

  modport master (
    input  req_valid, req_row, req_col, mem_dout, win_ready,
    output req_ready, req_err, mem_addr, mem_en, win_valid, win_data
  );

  modport slave (
    output req_valid, req_row, req_col, mem_dout, win_ready,
    input  req_ready, req_err, mem_addr, mem_en, win_valid, win_data
  );
endinterface

// File: rtl/block_fetch_sequencer.sv
// Fetches a BLOCK_SIZE-row x one-word window from a packed frame-buffer BRAM.
// Optional FETCH_ZERO_PAD_EN: rows past the image bottom read as zero instead of being rejected.
module block_fetch_sequencer #(
  parameter int unsigned BLOCK_SIZE = 6,
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned IMG_ROWS   = 320,
  parameter int unsigned ROW_WORDS  = 40,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                      clk_100mhz,
  input  logic                      sys_rst_n,
  block_fetch_sequencer_if.master   bus,
  output logic                      busy
);
  localparam int unsigned ROW_W  = $clog2(IMG_ROWS);
  localparam int unsigned COL_W  = $clog2(ROW_WORDS);
  localparam int unsigned ADDR_W = $clog2(IMG_ROWS * ROW_WORDS);
  localparam int unsigned WORD_W = BLOCK_SIZE * PIX_W;
  localparam int unsigned WIN_W  = BLOCK_SIZE * WORD_W;
  localparam int unsigned CNT_W  = $clog2(BLOCK_SIZE + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  cap_cnt;
  logic [RD_LAT-1:0] fl_vld;
  logic [RD_LAT-1:0] fl_pad;
  logic [WORD_W-1:0] slot [BLOCK_SIZE];
  logic              err_q;

  logic              col_ok, req_ok, row_pad, capture;
  logic              accept, reject, issue;
  logic              ready_c, win_valid_c, mem_en_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [ROW_W:0]    cur_row;
  logic [ADDR_W-1:0] cur_addr;
  logic [WIN_W-1:0]  win_flat;

  assign col_ok   = {1'b0, bus.req_col} < (COL_W+1)'(ROW_WORDS);
  assign cur_row  = {1'b0, row_q} + (ROW_W+1)'(issue_cnt);
  assign cur_addr = ADDR_W'(cur_row) * ADDR_W'(ROW_WORDS) + ADDR_W'(col_q);

`ifdef FETCH_ZERO_PAD_EN
  assign req_ok  = col_ok;
  assign row_pad = cur_row >= (ROW_W+1)'(IMG_ROWS);
`else
  logic row_ok;
  assign row_ok  = ({1'b0, bus.req_row} + (ROW_W+1)'(BLOCK_SIZE)) <= (ROW_W+1)'(IMG_ROWS);
  assign req_ok  = col_ok && row_ok;
  assign row_pad = 1'b0;
`endif

  assign capture = fl_vld[RD_LAT-1] && (cap_cnt < CNT_W'(BLOCK_SIZE));

  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready_c     = 1'b0;
    win_valid_c = 1'b0;
    mem_en_c    = 1'b0;
    mem_addr_c  = '0;
    busy        = 1'b1;
    accept      = 1'b0;
    reject      = 1'b0;
    issue       = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        busy    = 1'b0;
        if (bus.req_valid) begin
          if (req_ok) begin
            accept    = 1'b1;
            state_nxt = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ISSUE: begin
        issue      = 1'b1;
        mem_en_c   = !row_pad;
        mem_addr_c = row_pad ? '0 : cur_addr;
        if (issue_cnt == CNT_W'(BLOCK_SIZE - 1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // Look one capture ahead so win_valid rises the cycle after the last word lands.
        if ((cap_cnt == CNT_W'(BLOCK_SIZE)) ||
            (capture && (cap_cnt == CNT_W'(BLOCK_SIZE - 1))))
          state_nxt = HOLD;
      end
      HOLD: begin
        win_valid_c = 1'b1;
        if (bus.win_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!sys_rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      issue_cnt <= '0;
      cap_cnt   <= '0;
      fl_vld    <= '0;
      fl_pad    <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < BLOCK_SIZE; i++) slot[i] <= '0;
    end else begin
      err_q <= reject;
      // Padded rows still travel through the in-flight pipe so slot order and latency match real reads.
      fl_vld[0] <= issue;
      fl_pad[0] <= issue && row_pad;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        fl_vld[i] <= fl_vld[i-1];
        fl_pad[i] <= fl_pad[i-1];
      end
      if (accept) begin
        row_q     <= bus.req_row;
        col_q     <= bus.req_col;
        issue_cnt <= '0;
        cap_cnt   <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
      end
      if (capture) begin
        slot[cap_cnt] <= fl_pad[RD_LAT-1] ? '0 : bus.mem_dout;
        cap_cnt       <= cap_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < BLOCK_SIZE; i++) win_flat[i*WORD_W +: WORD_W] = slot[i];
  end

  assign bus.req_ready = ready_c;
  assign bus.req_err   = err_q;
  assign bus.mem_en    = mem_en_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.win_valid = win_valid_c;
  assign bus.win_data  = win_flat;
endmodule

// File: tb/tb_block_fetch_sequencer.sv
// Directed plus randomized bench for block_fetch_sequencer against a window-level reference model.
module tb_block_fetch_sequencer;
  localparam int unsigned BS = 6;
  localparam int unsigned PW = 8;
  localparam int unsigned IR = 320;
  localparam int unsigned RW = 40;
  localparam int unsigned RL = 2;
  localparam int unsigned WW = BS * PW;
  localparam int unsigned DW = BS * WW;
`ifdef FETCH_ZERO_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [WW-1:0] pipe1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  block_fetch_sequencer_if #(.BLOCK_SIZE(BS), .PIX_W(PW), .IMG_ROWS(IR), .ROW_WORDS(RW)) bus ();

  block_fetch_sequencer #(
    .BLOCK_SIZE(BS), .PIX_W(PW), .IMG_ROWS(IR), .ROW_WORDS(RW), .RD_LAT(RL)
  ) dut (
    .clk_100mhz(clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .busy      (busy)
  );

  function automatic logic [WW-1:0] word_of(input int unsigned a);
    logic [13:0] x;
    x = a[13:0];
    return {x, ~x, 20'h5A5A5};
  endfunction

  // BRAM: two-stage read pipe; returns noise when no read was issued.
  always @(posedge clk) begin
    pipe1        <= bus.mem_en ? word_of(int'(bus.mem_addr)) : WW'({$urandom(), $urandom()});
    bus.mem_dout <= pipe1;
  end

  function automatic logic [DW-1:0] exp_win(input int unsigned row, input int unsigned col);
    logic [DW-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < BS; i++)
      if (row + i < IR) w[i*WW +: WW] = word_of((row + i) * RW + col);
    return w;
  endfunction

  function automatic bit legal(input int unsigned row, input int unsigned col);
    return (col < RW) && (PAD_EN || (row + BS <= IR));
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req_ready"}, DW'(bus.req_ready), DW'(1'b1));
    check({tag, "_mem_en"},    DW'(bus.mem_en),    DW'(1'b0));
    check({tag, "_busy"},      DW'(busy),          DW'(1'b0));
    check({tag, "_win_valid"}, DW'(bus.win_valid), DW'(1'b0));
  endtask

  // Legal request: accept cycle is the current cycle; hold = cycles win_ready stays low.
  task automatic run_req(input int unsigned row, input int unsigned col, input int unsigned hold,
                         input bit nv, input int unsigned nrow, input int unsigned ncol,
                         output int unsigned t_valid);
    logic [DW-1:0] w;
    int unsigned r;
    w = exp_win(row, col);
    bus.req_valid = 1'b1;
    bus.req_row   = 9'(row);
    bus.req_col   = 6'(col);
    bus.win_ready = 1'b0;
    check("accept_ready", DW'(bus.req_ready), DW'(1'b1));
    tick();
    bus.req_valid = 1'b0;
    for (int unsigned k = 0; k < BS; k++) begin
      r = row + k;
      check("issue_en", DW'(bus.mem_en), DW'(r < IR));
      if (r < IR) check("issue_addr", DW'(bus.mem_addr), DW'(r * RW + col));
      check("issue_busy", DW'(busy), DW'(1'b1));
      check("issue_req_ready", DW'(bus.req_ready), DW'(1'b0));
      tick();
    end
    for (int unsigned k = 0; k < RL; k++) begin
      check("drain_en", DW'(bus.mem_en), DW'(1'b0));
      check("drain_valid", DW'(bus.win_valid), DW'(1'b0));
      tick();
    end
    t_valid = cyc;
    for (int unsigned h = 0; h <= hold; h++) begin
      check("hold_valid", DW'(bus.win_valid), DW'(1'b1));
      check("hold_data", bus.win_data, w);
      check("hold_req_ready", DW'(bus.req_ready), DW'(1'b0));
      check("hold_busy", DW'(busy), DW'(1'b1));
      if (h == hold) begin
        bus.win_ready = 1'b1;
        bus.req_valid = nv;
        bus.req_row   = 9'(nrow);
        bus.req_col   = 6'(ncol);
      end
      tick();
    end
    bus.win_ready = 1'b0;
    check("post_valid", DW'(bus.win_valid), DW'(1'b0));
    check("post_req_ready", DW'(bus.req_ready), DW'(1'b1));
    check("post_data_kept", bus.win_data, w);
  endtask

  task automatic run_bad(input int unsigned row, input int unsigned col);
    bus.req_valid = 1'b1;
    bus.req_row   = 9'(row);
    bus.req_col   = 6'(col);
    check("bad_ready", DW'(bus.req_ready), DW'(1'b1));
    tick();
    bus.req_valid = 1'b0;
    check("bad_err_pulse", DW'(bus.req_err), DW'(1'b1));
    check_idle_outputs("bad_t1");
    tick();
    check("bad_err_clear", DW'(bus.req_err), DW'(1'b0));
    check_idle_outputs("bad_t2");
  endtask

  initial begin
    int unsigned t1, t2, row, col;
    bus.req_valid = 1'b0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.win_ready = 1'b0;
    tick();
    tick();
    check("rst_req_err", DW'(bus.req_err), DW'(1'b0));
    check("rst_mem_addr", DW'(bus.mem_addr), DW'(0));
    check("rst_win_data", bus.win_data, '0);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    tick();

    run_req(10, 5, 0, 1'b0, 0, 0, t1);
    run_req(10, 5, 5, 1'b0, 0, 0, t1);

`ifdef FETCH_ZERO_PAD_EN
    run_req(316, 0, 0, 1'b0, 0, 0, t1);
`else
    run_bad(316, 0);
`endif
    run_bad(10, 40);
    run_bad(0, 63);

    // Reset during the fourth issue cycle, then a fresh window must carry no stale data.
    bus.req_valid = 1'b1;
    bus.req_row   = 9'd10;
    bus.req_col   = 6'd5;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_req_err", DW'(bus.req_err), DW'(1'b0));
    check("midrst_mem_addr", DW'(bus.mem_addr), DW'(0));
    check("midrst_win_data", bus.win_data, '0);
    check_idle_outputs("midrst");
    run_req(0, 0, 0, 1'b0, 0, 0, t1);

    run_req(20, 7, 0, 1'b1, 21, 8, t1);
    run_req(21, 8, 0, 1'b0, 0, 0, t2);
    check("b2b_spacing", DW'(t2 - t1), DW'(BS + RL + 2));

    for (int n = 0; n < 24; n++) begin
      row = $urandom_range(0, IR + 7);
      col = (($urandom() & 7) == 0) ? $urandom_range(RW, 63) : $urandom_range(0, RW - 1);
      if (legal(row, col)) run_req(row, col, $urandom_range(0, 3), 1'b0, 0, 0, t1);
      else                 run_bad(row, col);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/block_fetch_sequencer.md
Name: block_fetch_sequencer

Overview:
Sequences reads from one packed frame-buffer BRAM (left or right image, 48-bit words of six 8-bit pixels) to assemble a BLOCK_SIZE-row by one-word matching window for the stereo matcher.
- Accepts a window request (row, word column) via valid/ready.
- Issues BLOCK_SIZE BRAM reads and absorbs the BRAM read latency.
- Presents the assembled window to the disparity datapath via valid/ready.
- The top-level state machine instantiates one of these per image, replacing its empty UPDATE_BUFFERS step.

Parameters:
BLOCK_SIZE, 6, rows per window; pixels per word is also 6, giving word width 48.
PIX_W, 8, bits per pixel.
IMG_ROWS, 320, image rows (memory row count).
ROW_WORDS, 40, 48-bit words per image row.
RD_LAT, 2, BRAM read latency in cycles (2 = HIGH_PERFORMANCE).

Ports:
- clk_100mhz  in  1  system clock
- sys_rst_n  in  1  synchronous active-low reset
- req_valid  in  1  window request valid
- req_ready  out  1  block can accept a request
- req_row  in  $clog2(IMG_ROWS)  top row of window
- req_col  in  $clog2(ROW_WORDS)  word column
- req_err  out  1  one-cycle pulse: request rejected
- mem_addr  out  $clog2(IMG_ROWS*ROW_WORDS)  BRAM address = row*ROW_WORDS + col
- mem_en  out  1  read issued this cycle
- mem_dout  in  BLOCK_SIZE*PIX_W  BRAM read data, valid RD_LAT cycles after issue
- win_valid  out  1  window valid
- win_ready  in  1  consumer accepts window
- win_data  out  BLOCK_SIZE*BLOCK_SIZE*PIX_W  word i (row req_row+i) at bits [48*i +: 48]
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sys_rst_n low at a clock edge):
  - State goes to IDLE.
  - req_ready=1; req_err=0; mem_en=0; mem_addr=0; win_valid=0; win_data=0; busy=0.
  - The RD_LAT-deep in-flight valid shift register is cleared.
  - Reset mid-operation discards all in-flight reads. Late BRAM data is ignored.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - req_ready=1.
  - On req_valid, the block checks bounds:
    - Legal (req_row+BLOCK_SIZE <= IMG_ROWS and req_col < ROW_WORDS): latch row/col, clear issue and capture counters, go to ISSUE.
    - Illegal: assert req_err for exactly one cycle, stay in IDLE, issue no reads.
- ISSUE:
  - Runs BLOCK_SIZE consecutive cycles. Cycle k (0..BLOCK_SIZE-1) drives mem_en=1 and mem_addr=(row+k)*ROW_WORDS+col.
  - The address is computed at full address width; no truncation.
  - After the last issue, go to DRAIN.
- Capture:
  - Independent of state (ISSUE or DRAIN).
  - When the in-flight shift register output is 1, mem_dout is written to window slot capture_cnt, then capture_cnt increments.
- DRAIN:
  - mem_en=0.
  - When capture_cnt reaches BLOCK_SIZE, go to HOLD. win_valid rises the next cycle.
- Latency:
  - Accept cycle T0, issues T1..T6, last data T8, win_valid=1 at T9.
  - In general, win_valid rises BLOCK_SIZE+RD_LAT+1 cycles after accept.
- HOLD:
  - win_valid=1; win_data is stable and unchanged while win_ready=0.
  - On win_valid&&win_ready, go to IDLE; win_valid=0 the next cycle.
  - win_data keeps its last value until overwritten by the next capture.
- Back-pressure and throughput:
  - req_ready=0 in all non-IDLE states. Requests arriving while busy are not accepted; req_err is not asserted for them.
  - Best-case throughput is one window per BLOCK_SIZE+RD_LAT+2 cycles (10 with defaults).
- Simultaneous events:
  - Reset has priority over every handshake.
  - A win handshake and a new req_valid in the same cycle: the request waits. It is accepted one cycle later in IDLE.

Optional Feature:
Macro FETCH_ZERO_PAD_EN.
- Defined:
  - Requests with req_row+BLOCK_SIZE > IMG_ROWS are legal.
  - Window rows at or beyond IMG_ROWS get no BRAM read (mem_en=0 in that ISSUE cycle) and are filled with zero.
  - Slot ordering and latency are unchanged.
  - req_col >= ROW_WORDS is still rejected with req_err.
- Undefined: out-of-range rows are rejected as described in IDLE.

Test Plan:
- BRAM model returning word = address, RD_LAT=2. Request row 10, col 5 -> mem_addr 405,445,485,525,565,605 on T1..T6 with mem_en=1. win_valid at T9. win_data slots 0..5 = those values.
- Same request with win_ready held low 5 cycles after win_valid -> win_data stable. req_ready=0 and busy=1 throughout. Handshake on cycle 6 -> IDLE next cycle.
- Request row 316, col 0 (macro undefined) -> req_err high exactly one cycle, mem_en never asserted, state stays IDLE. Request col 40 -> same.
- Request row 316, col 0 with FETCH_ZERO_PAD_EN -> reads at addresses 12640..12760 step 40 (rows 316..319), then two cycles with mem_en=0. Slots 4,5 = 0. win_valid at T9.
- sys_rst_n low during ISSUE cycle 3 -> all outputs at reset values next cycle. New request row 0, col 0 -> window slots = 0,40,80,120,160,200 with no stale data.
- Back-to-back requests with win_ready=1 and req_valid held high -> second accept exactly one cycle after the first win handshake. Windows are spaced 10 cycles apart.
